audio_dac_tx: RTL and testbench
===============================

# audio_dac_tx

Serial transmitter that drives a 12-bit SPI-style audio DAC (DAC121S101-class, 16-bit frame) from the sample stream produced by the microphone ADC path. Accepts one 12-bit sample per strobe, buffers at most one pending sample, and shifts 16-bit frames out MSB first on `dac_sclk`/`dac_sync_n`/`dac_din`. Sits at the output end of the audio chain, mirroring the ADC capture block: samples arrive on a fire-and-forget strobe with no back-pressure.

## Interface

- `CLK_DIV`, 4: clk cycles per `dac_sclk` half-period (≥2); one bit period = 2·CLK_DIV cycles.
- `TWOS_COMP`, 0: 0 = input is offset binary, passed unchanged; 1 = input is two's complement, MSB inverted before transmission.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `sample_in`  in  12  audio sample.
- `sample_valid`  in  1  one-cycle strobe; `sample_in` valid this cycle.
- `dac_sclk`  out  1  serial clock; idles high.
- `dac_sync_n`  out  1  frame sync; low for the whole 16-bit frame.
- `dac_din`  out  1  serial data, MSB first.
- `busy`  out  1  high while a frame or inter-frame gap is in progress.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.
- `overrun`  out  1  one-cycle pulse when a pending sample is overwritten.

## Operation

- Frame word = {2'b00, 2'b00 (normal power mode), data[11:0]}; data = `sample_in`, with MSB inverted when TWOS_COMP=1.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: `sync_n`=1, `sclk`=1. On `sample_valid`, load the shifter, clear bit counter (0..15) and divider, go to SHIFT.
  - SHIFT: `sync_n`=0. Each bit period: `sclk` high for the first CLK_DIV cycles, low for the second CLK_DIV cycles. `din` updates at the start of each bit period (the `sclk` rising edge, or frame start) and is stable across the falling edge the DAC samples on. After the 16th bit period, go to GAP.
  - GAP: `sync_n`=1, `sclk`=1 for CLK_DIV cycles. On exit, go to SHIFT loading the holding register if it is full (clearing it), otherwise go to IDLE.
- Holding register, one entry, with a valid flag:
  - `sample_valid` in IDLE with holding empty: goes straight to the shifter; holding stays empty.
  - `sample_valid` in SHIFT/GAP: written to holding. If holding is already full, the old entry is overwritten and `overrun` pulses the next cycle.
  - `sample_valid` on the GAP-exit cycle while holding is full: the old entry moves to the shifter, the new sample goes to holding, and no overrun is raised.
- `busy` = state ≠ IDLE.
- Arithmetic:
  - Divider counter width is clog2(CLK_DIV) and wraps at CLK_DIV−1.
  - Bit counter is 4 bits and the terminal value is 15.
  - No saturation or scaling of the data.

## Timing

- All outputs are registered.
- Reset values: `dac_sclk`=1, `dac_sync_n`=1, `dac_din`=0, `busy`=0, `frame_done`=0, `overrun`=0. Holding register is empty, FSM is in IDLE.
- Latency: `sample_valid` at edge N (IDLE) → `dac_sync_n` falls and `dac_din`=bit15 (0) after edge N+1.
- Frame length: `sync_n` is low for exactly 32·CLK_DIV cycles, followed by a CLK_DIV-cycle gap.
- Sustained rate: one frame per 33·CLK_DIV cycles (132 at CLK_DIV=4).
- First falling `sclk` edge occurs CLK_DIV cycles after `sync_n` falls. The 16th falling edge occurs CLK_DIV cycles before `sync_n` rises.
- `frame_done` is high in the last SHIFT cycle.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously), and the pending sample is discarded. After release, the FSM is in IDLE.

## Test plan

- Reset release, CLK_DIV=4, then `sample_in`=12'hA5C strobe → after 1 cycle `sync_n`=0 for 128 cycles; 16 bits sampled on `sclk` falling edges = 16'h0A5C; `frame_done` pulses once; `busy` drops 132 cycles after the frame start.
- TWOS_COMP=1, `sample_in`=12'h800 → transmitted word is 16'h0000; `sample_in`=12'h7FF → 16'h0FFF.
- Strobes 12'h111 then 12'h222 (50 cycles apart) → two back-to-back frames with exactly a 4-cycle `sync_n`-high gap; no `overrun`.
- Strobes 12'h111, 12'h222, 12'h333 within one frame → `overrun` pulses once; second frame carries 12'h333; 12'h222 is never sent.
- Strobe coincident with the GAP-exit cycle while holding is full → both pending and new samples are sent in order; `overrun`=0.
- `rst` asserted at bit 7 of a frame with holding full → outputs return to reset values the same cycle; after release, no frame starts without a new strobe.

Source files
------------

// File: rtl/audio_dac_tx.sv
// Sends one 16-bit frame per 12-bit audio sample to a DAC121S101-class DAC, MSB first.
// A single holding register keeps one sample while the current frame is still shifting.
module audio_dac_tx #(
  parameter int CLK_DIV   = 4,
  parameter int TWOS_COMP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic [11:0]   hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
  logic          sclk_q, sclk_d;
  logic          sync_n_q, sync_n_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;

  logic [11:0] data_in;
  logic        div_wrap;

  // The holding register stores data already converted to offset binary.
  assign data_in  = {sample_in[11] ^ (TWOS_COMP != 0), sample_in[10:0]};
  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    sclk_d       = sclk_q;
    sync_n_d     = sync_n_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          state_d  = SHIFT;
          shift_d  = {4'b0000, data_in};
          div_d    = '0;
          bit_d    = 4'd0;
          sclk_d   = 1'b1;
          sync_n_d = 1'b0;
        end
      end

      SHIFT: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        // sclk_q low means we are in the second half of a bit period.
        if (div_wrap) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == 4'd15) begin
            state_d  = GAP;
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
          end else begin
            sclk_d  = 1'b1;
            bit_d   = bit_q + 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
        frame_done_d = !sclk_q && (bit_q == 4'd15) && (div_q == DIV_PRE);
        if (sample_valid) begin
          hold_d       = data_in;
          hold_valid_d = 1'b1;
          overrun_d    = hold_valid_q;
        end
      end

      GAP: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          if (hold_valid_q || sample_valid) begin
            state_d  = SHIFT;
            bit_d    = 4'd0;
            sync_n_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
          // A pending sample goes first; a coincident strobe takes its place in holding.
          if (hold_valid_q) begin
            shift_d      = {4'b0000, hold_q};
            hold_valid_d = sample_valid;
            if (sample_valid) hold_d = data_in;
          end else if (sample_valid) begin
            shift_d = {4'b0000, data_in};
          end
        end else if (sample_valid) begin
          hold_d       = data_in;
          hold_valid_d = 1'b1;
          overrun_d    = hold_valid_q;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= 4'd0;
      shift_q      <= 16'd0;
      hold_q       <= 12'd0;
      hold_valid_q <= 1'b0;
      sclk_q       <= 1'b1;
      sync_n_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sclk_q       <= sclk_d;
      sync_n_q     <= sync_n_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_din    = shift_q[15];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_audio_dac_tx.sv
// Scoreboard bench for audio_dac_tx: channel 0 uses offset binary, channel 1 two's complement.
// A schedule-level model predicts frame words, start edges and overrun edges per channel.
module tb_audio_dac_tx;
  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 33 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0][11:0] s_in = '0;
  logic [1:0] s_valid = '0;
  logic [1:0] sclk, sync_n, din, busy, fdone, ovr;

  int tests = 0;
  int fails = 0;
  int ovr_seen [2] = '{0, 0};
  int unsigned t = 0;

  always #5 clk = ~clk;
  always @(posedge clk) t <= t + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  for (genvar k = 0; k < 2; k++) begin : ch
    audio_dac_tx #(.CLK_DIV(CLK_DIV), .TWOS_COMP(k)) dut (
      .clk(clk), .rst(rst), .sample_in(s_in[k]), .sample_valid(s_valid[k]),
      .dac_sclk(sclk[k]), .dac_sync_n(sync_n[k]), .dac_din(din[k]),
      .busy(busy[k]), .frame_done(fdone[k]), .overrun(ovr[k])
    );

    logic [15:0] exp_word_q [$];
    int unsigned exp_start_q [$];
    int unsigned exp_ovr_q [$];
    int unsigned cur_end = 0;
    bit hold_v = 0;
    logic [11:0] hold_val = '0;

    function automatic logic [15:0] word_of(input logic [11:0] s);
      return {4'b0000, s[11] ^ (k == 1), s[10:0]};
    endfunction

    // Model: a frame occupies PERIOD edges from its load; one sample may wait behind it.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        exp_word_q.delete();
        exp_start_q.delete();
        exp_ovr_q.delete();
        hold_v  = 0;
        cur_end = 0;
      end else if (hold_v && t == cur_end) begin
        exp_word_q.push_back(word_of(hold_val));
        exp_start_q.push_back(t);
        cur_end = t + PERIOD;
        if (s_valid[k]) hold_val = s_in[k];
        else hold_v = 0;
      end else if (s_valid[k]) begin
        if (t >= cur_end) begin
          exp_word_q.push_back(word_of(s_in[k]));
          exp_start_q.push_back(t);
          cur_end = t + PERIOD;
        end else begin
          if (hold_v) exp_ovr_q.push_back(t);
          hold_val = s_in[k];
          hold_v   = 1;
        end
      end
    end

    logic [15:0] rx = '0;
    logic [15:0] exp_w = '0;
    int nbits = 0, low_cnt = 0, fd_cnt = 0;
    bit in_frame = 0, prev_sclk = 1, prev_fd = 0, prev_busy = 0;
    int unsigned last_start = 0;

    // Monitor: decode frames from the serial pins and compare against the model queues.
    always @(negedge clk) begin
      if (!rst) begin
        in_frame  = 0;
        prev_sclk = 1;
        prev_fd   = 0;
        prev_busy = 0;
      end else begin
        if (!in_frame && !sync_n[k]) begin
          in_frame = 1; nbits = 0; low_cnt = 0; fd_cnt = 0; rx = '0;
          last_start = t - 1;
          check($sformatf("ch%0d_frame_expected", k), exp_start_q.size(), 1);
          if (exp_start_q.size() > 0) begin
            check($sformatf("ch%0d_frame_start_edge", k), last_start, exp_start_q.pop_front());
            exp_w = exp_word_q.pop_front();
          end
        end
        if (in_frame) begin
          if (!sync_n[k]) begin
            low_cnt++;
            if (prev_sclk && !sclk[k]) begin
              rx = {rx[14:0], din[k]};
              nbits++;
            end
            fd_cnt += int'(fdone[k]);
            prev_fd = fdone[k];
          end else begin
            in_frame = 0;
            check($sformatf("ch%0d_frame_word", k), rx, exp_w);
            check($sformatf("ch%0d_falling_edges", k), nbits, 16);
            check($sformatf("ch%0d_sync_low_cycles", k), low_cnt, 32 * CLK_DIV);
            check($sformatf("ch%0d_frame_done_count", k), fd_cnt, 1);
            check($sformatf("ch%0d_frame_done_last", k), prev_fd, 1);
          end
        end
        if (ovr[k]) begin
          ovr_seen[k]++;
          check($sformatf("ch%0d_overrun_expected", k), exp_ovr_q.size() > 0, 1);
          if (exp_ovr_q.size() > 0)
            check($sformatf("ch%0d_overrun_edge", k), t - 1, exp_ovr_q.pop_front());
        end
        if (prev_busy && !busy[k])
          check($sformatf("ch%0d_busy_fall", k), (t - 1) - last_start, PERIOD);
        prev_busy = busy[k];
        prev_sclk = sclk[k];
      end
    end
  end

  task automatic applyStimulus(input int k, input logic [11:0] v);
    @(negedge clk);
    s_in[k]    = v;
    s_valid[k] = 1'b1;
    @(negedge clk);
    s_valid[k] = 1'b0;
  endtask

  task automatic strobeAt(input int k, input logic [11:0] v, input int unsigned edge_idx);
    while (t < edge_idx) @(negedge clk);
    s_in[k]    = v;
    s_valid[k] = 1'b1;
    @(negedge clk);
    s_valid[k] = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input int k, input string tag);
    check({tag, "_sclk"}, sclk[k], 1);
    check({tag, "_sync_n"}, sync_n[k], 1);
    check({tag, "_din"}, din[k], 0);
    check({tag, "_busy"}, busy[k], 0);
    check({tag, "_frame_done"}, fdone[k], 0);
    check({tag, "_overrun"}, ovr[k], 0);
  endtask

  initial begin
    int unsigned e0;
    int ovr_before;

    waitCycles(3);
    checkOutput(0, "reset_ch0");
    checkOutput(1, "reset_ch1");
    rst = 1'b1;
    waitCycles(2);

    applyStimulus(0, 12'hA5C);
    waitCycles(140);

    applyStimulus(1, 12'h800);
    waitCycles(140);
    applyStimulus(1, 12'h7FF);
    waitCycles(140);

    ovr_before = ovr_seen[0];
    applyStimulus(0, 12'h111);
    waitCycles(50);
    applyStimulus(0, 12'h222);
    waitCycles(300);
    check("back_to_back_overruns", ovr_seen[0] - ovr_before, 0);

    ovr_before = ovr_seen[0];
    applyStimulus(0, 12'h111);
    waitCycles(20);
    applyStimulus(0, 12'h222);
    waitCycles(20);
    applyStimulus(0, 12'h333);
    waitCycles(300);
    check("overwrite_overruns", ovr_seen[0] - ovr_before, 1);

    ovr_before = ovr_seen[0];
    applyStimulus(0, 12'h444);
    e0 = t - 1;
    waitCycles(30);
    applyStimulus(0, 12'h555);
    strobeAt(0, 12'h666, e0 + PERIOD);
    waitCycles(420);
    check("gap_exit_overruns", ovr_seen[0] - ovr_before, 0);

    applyStimulus(0, 12'h777);
    e0 = t - 1;
    waitCycles(10);
    applyStimulus(0, 12'h888);
    while (t < e0 + 7 * 2 * CLK_DIV + 3) @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput(0, "async_reset");
    waitCycles(3);
    rst = 1'b1;
    waitCycles(300);
    checkOutput(0, "after_reset_idle");

    for (int i = 0; i < 80; i++) begin
      waitCycles($urandom_range(1, 180));
      applyStimulus(int'($urandom_range(0, 1)), 12'($urandom));
    end
    waitCycles(450);

    check("ch0_frames_left", ch[0].exp_start_q.size(), 0);
    check("ch1_frames_left", ch[1].exp_start_q.size(), 0);
    check("ch0_overruns_left", ch[0].exp_ovr_q.size(), 0);
    check("ch1_overruns_left", ch[1].exp_ovr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
